reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin write arbiter driving the load/in1 inputs of NREG Register instances.
// Optional grant counters are built when REG_WRITE_ARB_STATS_EN is defined.
module reg_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [1:0]        addr_a,
  input  logic [1:0]        addr_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [NREG-1:0]   load,
  output logic [DATA_W-1:0] wdata,
  output logic              busy
`ifdef REG_WRITE_ARB_STATS_EN
  ,
  output logic [15:0]       cnt_a,
  output logic [15:0]       cnt_b
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t state_r;
  logic   prefer_b_r;
  logic   win_a_s;
  logic   win_b_s;

  function automatic logic [NREG-1:0] addr_onehot(input logic [1:0] idx);
    logic [NREG-1:0] v;
    v      = {NREG{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin winner selection; only consulted while idle.
  always_comb begin
    win_a_s = 1'b0;
    win_b_s = 1'b0;
    if (req_a && req_b) begin
      if (prefer_b_r) begin
        win_b_s = 1'b1;
      end else begin
        win_a_s = 1'b1;
      end
    end else if (req_a) begin
      win_a_s = 1'b1;
    end else if (req_b) begin
      win_b_s = 1'b1;
    end else begin
      win_a_s = 1'b0;
      win_b_s = 1'b0;
    end
  end

  // Arbiter FSM with registered grant, load, data and busy outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      load       <= {NREG{1'b0}};
      wdata      <= {DATA_W{1'b0}};
      busy       <= 1'b0;
      prefer_b_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_a_s) begin
            state_r    <= GRANT;
            gnt_a      <= 1'b1;
            gnt_b      <= 1'b0;
            load       <= addr_onehot(addr_a);
            wdata      <= data_a;
            busy       <= 1'b1;
            prefer_b_r <= 1'b1;
          end else if (win_b_s) begin
            state_r    <= GRANT;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b1;
            load       <= addr_onehot(addr_b);
            wdata      <= data_b;
            busy       <= 1'b1;
            prefer_b_r <= 1'b0;
          end else begin
            state_r <= IDLE;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            load    <= {NREG{1'b0}};
            busy    <= 1'b0;
          end
        end
        // GRANT is a single cycle; requests seen here are deliberately dropped.
        GRANT: begin
          state_r <= IDLE;
          gnt_a   <= 1'b0;
          gnt_b   <= 1'b0;
          load    <= {NREG{1'b0}};
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          gnt_a   <= 1'b0;
          gnt_b   <= 1'b0;
          load    <= {NREG{1'b0}};
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef REG_WRITE_ARB_STATS_EN
  // Per-requester grant counters, free-running wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a <= 16'd0;
      cnt_b <= 16'd0;
    end else if (state_r == IDLE) begin
      if (win_a_s) begin
        cnt_a <= cnt_a + 16'd1;
      end else if (win_b_s) begin
        cnt_b <= cnt_b + 16'd1;
      end else begin
        cnt_a <= cnt_a;
        cnt_b <= cnt_b;
      end
    end else begin
      cnt_a <= cnt_a;
      cnt_b <= cnt_b;
    end
  end
`endif

endmodule
